pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the five-stage MIPS core. It is the successor to the fixed-field stage registers and replaces D/E, E/M and M/W with one block.
- Carries instruction, PC, a packed operand payload, destination register and hazard Tnew, plus a valid bit.
- Supports stall (hold), flush (bubble insertion), optional per-stage Tnew decrement, optional PC retention on flush (for EPC tracking) and a saturating bubble counter.

---
 rtl/pipe_stage_reg_if.sv | 36 +++
 rtl/pipe_stage_reg.sv | 104 ++++++++++
 tb/tb_pipe_stage_reg.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bus between a pipeline stage and its inter-stage register: upstream fields in,
// registered fields and the bubble counter out.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 32,
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 16
);
    logic              en;
    logic              flush;
    logic              clr_cnt;
    logic              valid_in;
    logic [31:0]       instr_in;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] data_in;
    logic [4:0]        a3_in;
    logic [TNEW_W-1:0] tnew_in;

    logic              valid_out;
    logic [31:0]       instr_out;
    logic [PC_W-1:0]   pc_out;
    logic [DATA_W-1:0] data_out;
    logic [4:0]        a3_out;
    logic [TNEW_W-1:0] tnew_out;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output en, flush, clr_cnt, valid_in, instr_in, pc_in, data_in, a3_in, tnew_in,
        input  valid_out, instr_out, pc_out, data_out, a3_out, tnew_out, bubble_cnt
    );

    modport slave (
        input  en, flush, clr_cnt, valid_in, instr_in, pc_in, data_in, a3_in, tnew_in,
        output valid_out, instr_out, pc_out, data_out, a3_out, tnew_out, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage register (D/E, E/M, M/W) with stall, flush, optional
// Tnew decrement, optional PC retention on flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int DATA_W           = 128,
    parameter int PC_W             = 32,
    parameter int TNEW_W           = 2,
    parameter bit TNEW_DEC         = 1'b0,
    parameter bit KEEP_PC_ON_FLUSH = 1'b0,
    parameter int CNT_W            = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    pipe_stage_reg_if.slave bus
);
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [4:0]        a3_q,    a3_d;
    logic [TNEW_W-1:0] tnew_q,  tnew_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              bubble_cap;
    logic [TNEW_W-1:0] tnew_ld;

    // Saturating decrement: a Tnew of 0 means "ready now" and must not wrap.
    always_comb begin
        tnew_ld = bus.tnew_in;
        if (TNEW_DEC && (bus.tnew_in != '0)) begin
            tnew_ld = bus.tnew_in - TNEW_W'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        data_d  = data_q;
        a3_d    = a3_q;
        tnew_d  = tnew_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc_d    = KEEP_PC_ON_FLUSH ? bus.pc_in : '0;
            data_d  = '0;
            a3_d    = '0;
            tnew_d  = '0;
        end else if (bus.en) begin
            valid_d = bus.valid_in;
            pc_d    = bus.pc_in;
            if (bus.valid_in) begin
                instr_d = bus.instr_in;
                data_d  = bus.data_in;
                a3_d    = bus.a3_in;
                tnew_d  = tnew_ld;
            end else begin
                // Zero a3 keeps bubbles out of forwarding and stall detection.
                instr_d = '0;
                data_d  = '0;
                a3_d    = '0;
                tnew_d  = '0;
            end
        end
    end

    assign bubble_cap = bus.flush | (bus.en & ~bus.valid_in);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (bubble_cap && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_out  = valid_q;
    assign bus.instr_out  = instr_q;
    assign bus.pc_out     = pc_q;
    assign bus.data_out   = data_q;
    assign bus.a3_out     = a3_q;
    assign bus.tnew_out   = tnew_q;
    assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: dut_a (TNEW_DEC=1, KEEP_PC=0, CNT_W=4) and dut_b (TNEW_DEC=0,
// KEEP_PC=1, CNT_W=16) see identical stimulus.
module tb_pipe_stage_reg;
    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    pipe_stage_reg_if #(.CNT_W(4))  bus_a ();
    pipe_stage_reg_if #(.CNT_W(16)) bus_b ();

    pipe_stage_reg #(.TNEW_DEC(1'b1), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_a)
    );
    pipe_stage_reg #(.TNEW_DEC(1'b0), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic fl, input logic clr, input logic vld,
                          input logic [31:0] instr, input logic [31:0] pc,
                          input logic [127:0] data, input logic [4:0] a3, input logic [1:0] tnew);
        bus_a.en = en;  bus_a.flush = fl;  bus_a.clr_cnt = clr;  bus_a.valid_in = vld;
        bus_a.instr_in = instr;  bus_a.pc_in = pc;  bus_a.data_in = data;
        bus_a.a3_in = a3;  bus_a.tnew_in = tnew;
        bus_b.en = en;  bus_b.flush = fl;  bus_b.clr_cnt = clr;  bus_b.valid_in = vld;
        bus_b.instr_in = instr;  bus_b.pc_in = pc;  bus_b.data_in = data;
        bus_b.a3_in = a3;  bus_b.tnew_in = tnew;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, " valid_a"}, 128'(bus_a.valid_out), 128'd0);
        check_val({tag, " instr_a"}, 128'(bus_a.instr_out), 128'd0);
        check_val({tag, " pc_a"},    128'(bus_a.pc_out),    128'd0);
        check_val({tag, " data_a"},  bus_a.data_out,        128'd0);
        check_val({tag, " a3_a"},    128'(bus_a.a3_out),    128'd0);
        check_val({tag, " tnew_a"},  128'(bus_a.tnew_out),  128'd0);
        check_val({tag, " cnt_a"},   128'(bus_a.bubble_cnt), 128'd0);
        check_val({tag, " pc_b"},    128'(bus_b.pc_out),    128'd0);
        check_val({tag, " cnt_b"},   128'(bus_b.bubble_cnt), 128'd0);
    endtask

    localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 5'd0, 2'd0);
        #3;
        check_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h8C01_0004, 32'h3004, D1, 5'd1, 2'd2);
        step();
        check_val("load instr_a", 128'(bus_a.instr_out), 128'h8C01_0004);
        check_val("load pc_a",    128'(bus_a.pc_out),    128'h3004);
        check_val("load a3_a",    128'(bus_a.a3_out),    128'd1);
        check_val("load valid_a", 128'(bus_a.valid_out), 128'd1);
        check_val("load data_a",  bus_a.data_out,        D1);
        check_val("load tnew_a dec2", 128'(bus_a.tnew_out), 128'd1);
        check_val("load tnew_b nodec2", 128'(bus_b.tnew_out), 128'd2);

        // Asynchronous reset between edges, held across an edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async rst");
        step();
        check_zero("rst held");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("post rst instr", 128'(bus_a.instr_out), 128'h8C01_0004);
        check_val("post rst pc",    128'(bus_a.pc_out),    128'h3004);

        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h3006, D2, 5'd7, 2'd0);
        step();
        check_val("tnew_a zero", 128'(bus_a.tnew_out), 128'd0);
        check_val("tnew_b zero", 128'(bus_b.tnew_out), 128'd0);
        check_val("data_b d2",   bus_b.data_out,        D2);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h3006, D2, 5'd7, 2'd3);
        step();
        check_val("tnew_a dec3", 128'(bus_a.tnew_out), 128'd2);
        check_val("tnew_b nodec3", 128'(bus_b.tnew_out), 128'd3);

        // Stall: three held cycles with changing inputs.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0123_4567, 32'h3008, D1, 5'd9, 2'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0000 + i, 32'h4000 + 4 * i, D2, 5'd3, 2'd3);
            step();
            check_val("hold pc_a",    128'(bus_a.pc_out),    128'h3008);
            check_val("hold instr_b", 128'(bus_b.instr_out), 128'h0123_4567);
            check_val("hold tnew_a",  128'(bus_a.tnew_out),  128'd1);
            check_val("hold cnt_a",   128'(bus_a.bubble_cnt), 128'd0);
        end

        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'hBBBB_BBBB, 32'h300C, D2, 5'd4, 2'd2);
        step();
        check_val("flush valid_a", 128'(bus_a.valid_out), 128'd0);
        check_val("flush a3_a",    128'(bus_a.a3_out),    128'd0);
        check_val("flush data_a",  bus_a.data_out,        128'd0);
        check_val("flush pc_a",    128'(bus_a.pc_out),    128'd0);
        check_val("flush pc_b",    128'(bus_b.pc_out),    128'h300C);
        check_val("flush cnt_a",   128'(bus_a.bubble_cnt), 128'd1);
        check_val("flush cnt_b",   128'(bus_b.bubble_cnt), 128'd1);

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h3010, D1, 5'd31, 2'd3);
        step();
        check_val("bub valid_a", 128'(bus_a.valid_out), 128'd0);
        check_val("bub a3_a",    128'(bus_a.a3_out),    128'd0);
        check_val("bub instr_a", 128'(bus_a.instr_out), 128'd0);
        check_val("bub data_b",  bus_b.data_out,        128'd0);
        check_val("bub tnew_b",  128'(bus_b.tnew_out),  128'd0);
        check_val("bub pc_a",    128'(bus_a.pc_out),    128'h3010);
        check_val("bub cnt_a",   128'(bus_a.bubble_cnt), 128'd2);

        // Clear while holding leaves the data path alone.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h5555_5555, 32'h5000, D2, 5'd5, 2'd1);
        step();
        check_val("clr cnt_a", 128'(bus_a.bubble_cnt), 128'd0);
        check_val("clr pc_b",  128'(bus_b.pc_out),     128'h3010);

        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h6000 + 4 * i, D1, 5'd2, 2'd2);
            step();
        end
        check_val("sat cnt_a",  128'(bus_a.bubble_cnt), 128'd15);
        check_val("cnt_b 20",   128'(bus_b.bubble_cnt), 128'd20);
        check_val("sat pc_b",   128'(bus_b.pc_out),     128'h604C);

        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h7000, D1, 5'd2, 2'd2);
        step();
        check_val("clr+flush cnt_a", 128'(bus_a.bubble_cnt), 128'd0);
        check_val("clr+flush cnt_b", 128'(bus_b.bubble_cnt), 128'd0);

        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h7004, D1, 5'd2, 2'd2);
        step();
        check_val("after clr cnt_a", 128'(bus_a.bubble_cnt), 128'd1);
        check_val("after clr cnt_b", 128'(bus_b.bubble_cnt), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
